// File: rtl/serial_link_pkg.sv
// Shared definitions for the transmisor/receptor serial link: FSM state
// encoding and the default frame geometry both ends must agree on.
package serial_link_pkg;

  localparam int SIZESREG_DEF   = 16;
  localparam int GAP_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } st_t;

endpackage

// File: rtl/transmisor_if.sv
// Parallel-side handshake plus serial link outputs of the transmisor.
// slave = the transmisor itself, master = the parallel source / observer.
interface transmisor_if #(
    parameter int SIZESREG = 16
) ();
    // start is accepted on a rising CLK edge where start=1 and ready=1;
    // data_in is sampled only on that edge, and done pulses once per frame.
    logic [SIZESREG-1:0] data_in;
    logic                start;
    logic                ready;
    logic                enable_out;
    logic                signal_out;
    logic                done;

    modport master (
        output data_in, start,
        input  ready, enable_out, signal_out, done
    );

    modport slave (
        input  data_in, start,
        output ready, enable_out, signal_out, done
    );
endinterface

// File: rtl/transmisor_piso.sv
// Parallel-load / serial-out register. serial_next is the bit that sits at the
// serial end after the operation requested this cycle, so the caller can register it.
module transmisor_piso #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load,
    input  logic             shift,
    input  logic             lsb_first,
    input  logic [WIDTH-1:0] par_in,
    output logic             serial_next
);
    logic [WIDTH-1:0] tx_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_reg <= '0;
        end else if (load) begin
            tx_reg <= par_in;
        end else if (shift) begin
            if (lsb_first) tx_reg <= {1'b0, tx_reg[WIDTH-1:1]};
            else           tx_reg <= {tx_reg[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        serial_next = 1'b0;
        if (load)       serial_next = lsb_first ? par_in[0] : par_in[WIDTH-1];
        else if (shift) serial_next = lsb_first ? tx_reg[1] : tx_reg[WIDTH-2];
        else            serial_next = lsb_first ? tx_reg[0] : tx_reg[WIDTH-1];
    end
endmodule

// File: rtl/transmisor.sv
// Serializes a parallel word onto an enable/signal pair for the receptor.
// Define TRANSMISOR_LSB_FIRST_EN to send LSB first instead of MSB first.
module transmisor
    import serial_link_pkg::*;
#(
    parameter int SIZESREG   = SIZESREG_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic         CLK,
    input  logic         RST_N,
    transmisor_if.slave  bus,
    output st_t          state_dbg
);
    localparam int BW = $clog2(SIZESREG);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(SIZESREG - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

`ifdef TRANSMISOR_LSB_FIRST_EN
    localparam logic LSB_FIRST = 1'b1;
`else
    localparam logic LSB_FIRST = 1'b0;
`endif

    st_t           state, state_n;
    logic [BW-1:0] bit_cnt, bit_cnt_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    logic          load, shift, serial_next;

    transmisor_piso #(.WIDTH(SIZESREG)) u_piso (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .load        (load),
        .shift       (shift),
        .lsb_first   (LSB_FIRST),
        .par_in      (bus.data_in),
        .serial_next (serial_next)
    );

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_n   = ST_SHIFT;
                    bit_cnt_n = '0;
                    load      = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt == BIT_LAST) begin
                    state_n   = ST_GAP;
                    gap_cnt_n = '0;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    shift     = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_n = ST_IDLE;
                else                     gap_cnt_n = gap_cnt + 1'b1;
            end
            default: begin
                state_n   = ST_IDLE;
                bit_cnt_n = '0;
                gap_cnt_n = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state          <= ST_IDLE;
            bit_cnt        <= '0;
            gap_cnt        <= '0;
            bus.ready      <= 1'b1;
            bus.enable_out <= 1'b0;
            bus.signal_out <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            state          <= state_n;
            bit_cnt        <= bit_cnt_n;
            gap_cnt        <= gap_cnt_n;
            bus.ready      <= (state_n == ST_IDLE);
            bus.enable_out <= (state_n == ST_SHIFT);
            bus.signal_out <= (state_n == ST_SHIFT) && serial_next;
            bus.done       <= (state_n == ST_GAP) && (gap_cnt_n == GAP_LAST);
        end
    end

    assign state_dbg = state;
endmodule

// File: tb/tb_transmisor.sv
// Bench for transmisor: frame-offset reference model, receptor-style
// deserializer with expected-word queue, and directed frame scenarios.
module tb_transmisor;
  import serial_link_pkg::*;

  localparam int S = SIZESREG_DEF;
  localparam int G = GAP_CYCLES_DEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [S-1:0] data_in = '0;
  st_t state_dbg;
  int checks = 0;
  int errors = 0;

  transmisor_if #(.SIZESREG(S)) bus ();
  assign bus.start   = start;
  assign bus.data_in = data_in;

  transmisor #(.SIZESREG(S), .GAP_CYCLES(G)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the current frame, counted in edges
  // since acceptance. 1..S are data cycles, S+1..S+G the gap.
  bit active = 1'b0;
  int since = 0;
  logic [S-1:0] word = '0;
  logic [S-1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (active && since <= S && exp_q.size() > 0) void'(exp_q.pop_back());
      active = 1'b0;
      since = 0;
    end else begin
      bit m_rdy;
      m_rdy = !active || since > S + G;
      if (active) since++;
      if (m_rdy && start) begin
        active = 1'b1;
        since = 1;
        word = data_in;
        exp_q.push_back(data_in);
      end
    end
  end

  int done_cnt = 0;

  always @(negedge clk) begin
    logic e_en, e_sig, e_done, e_rdy;
    int b;
    e_en = active && since >= 1 && since <= S;
`ifdef TRANSMISOR_LSB_FIRST_EN
    b = since - 1;
`else
    b = S - since;
`endif
    e_sig = e_en ? word[b] : 1'b0;
    e_done = active && since == S + G;
    e_rdy = !(active && since <= S + G);
    check("enable_out", 32'(bus.enable_out), 32'(e_en));
    check("signal_out", 32'(bus.signal_out), 32'(e_sig));
    check("done", 32'(bus.done), 32'(e_done));
    check("ready", 32'(bus.ready), 32'(e_rdy));
    if (rst_n && bus.done) done_cnt++;
  end

  // Receptor-style deserializer feeding the expected-word scoreboard.
  logic [S-1:0] rx_sh = '0;
  logic [S-1:0] rx_last = '0;
  int rx_cnt = 0;
  bit rx_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_cnt = 0;
      rx_prev = 1'b0;
    end else begin
      if (bus.enable_out) begin
`ifdef TRANSMISOR_LSB_FIRST_EN
        rx_sh = {bus.signal_out, rx_sh[S-1:1]};
`else
        rx_sh = {rx_sh[S-2:0], bus.signal_out};
`endif
        rx_cnt++;
      end else if (rx_prev) begin
        rx_last = rx_sh;
        check("rx_bit_count", 32'(rx_cnt), 32'(S));
        if (exp_q.size() == 0) check("rx_unexpected_frame", 32'(1), 32'(0));
        else check("rx_word", 32'(rx_sh), 32'(exp_q.pop_front()));
        rx_cnt = 0;
      end
      rx_prev = bus.enable_out;
    end
  end

  task automatic run_frame(input logic [S-1:0] w, output logic [S-1:0] stream,
                           output int en_n, output int done_n, output int rdy_n);
    stream = '0; en_n = 0; done_n = 0; rdy_n = 0;
    @(posedge clk); #1; data_in = w; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; data_in = ~w;
    for (int n = 1; n <= 22; n++) begin
      @(negedge clk);
      if (bus.enable_out) begin
        stream = {stream[S-2:0], bus.signal_out};
        en_n++;
      end
      if (bus.done && done_n == 0) done_n = n;
      if (bus.ready && rdy_n == 0) rdy_n = n;
    end
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ready && n < budget);
    check("wait_ready", 32'(bus.ready), 32'(1));
  endtask

  task automatic send(input logic [S-1:0] w);
    @(posedge clk); #1; data_in = w; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_ready(40);
  endtask

  initial begin
    logic [S-1:0] st;
    int en_n, done_n, rdy_n, d0, lows;
    bit in_first, gap_seen;

    repeat (3) @(negedge clk);
    check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    check("reset_ready", 32'(bus.ready), 32'(1));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame timing and bit order
    run_frame(16'hA5C3, st, en_n, done_n, rdy_n);
`ifdef TRANSMISOR_LSB_FIRST_EN
    check("a5c3_stream", 32'(st), 32'h0000C3A5);
`else
    check("a5c3_stream", 32'(st), 32'h0000A5C3);
`endif
    check("a5c3_enable_cycles", 32'(en_n), 32'd16);
    check("a5c3_done_cycle", 32'(done_n), 32'd18);
    check("a5c3_ready_cycle", 32'(rdy_n), 32'd19);
    check("a5c3_rx", 32'(rx_last), 32'h0000A5C3);

    run_frame(16'h0001, st, en_n, done_n, rdy_n);
`ifdef TRANSMISOR_LSB_FIRST_EN
    check("0001_stream", 32'(st), 32'h00008000);
`else
    check("0001_stream", 32'(st), 32'h00000001);
`endif

    // Loopback words
    send(16'h00FF);
    check("loop_00ff", 32'(rx_last), 32'h000000FF);
    send(16'hFFFF);
    check("loop_ffff", 32'(rx_last), 32'h0000FFFF);
    send(16'h0001);
    check("loop_0001", 32'(rx_last), 32'h00000001);

    // Busy rejection: second start during SHIFT is dropped
    d0 = done_cnt;
    @(posedge clk); #1; data_in = 16'h1234; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; data_in = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_ready(40);
    repeat (3) @(negedge clk);
    check("busy_done_count", 32'(done_cnt - d0), 32'd1);
    check("busy_rx", 32'(rx_last), 32'h00001234);

    // Back-to-back with start held high
    d0 = done_cnt; lows = 0; in_first = 1'b0; gap_seen = 1'b0;
    @(posedge clk); #1; data_in = 16'hAAAA; start = 1'b1;
    @(posedge clk); #1; data_in = 16'h5555;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 20) start = 1'b0;
      if (bus.enable_out) begin
        if (lows > 0) gap_seen = 1'b1;
        in_first = 1'b1;
      end else if (in_first && !gap_seen) begin
        lows++;
      end
    end
    check("b2b_low_cycles", 32'(lows), 32'd3);
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    check("b2b_rx", 32'(rx_last), 32'h00005555);

    // Reset mid-frame
    d0 = done_cnt;
    @(posedge clk); #1; data_in = 16'h5A5A; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    #1; rst_n = 1'b0;
    @(negedge clk);
    check("rst_enable", 32'(bus.enable_out), 32'd0);
    check("rst_signal", 32'(bus.signal_out), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    run_frame(16'hC3C3, st, en_n, done_n, rdy_n);
    check("c3c3_stream", 32'(st), 32'h0000C3C3);
    check("c3c3_done_cycle", 32'(done_n), 32'd18);
    check("c3c3_rx", 32'(rx_last), 32'h0000C3C3);

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
